// File: rtl/imem_loader.sv
// Framed byte-stream program loader for the CPU instruction memory.
// Assembles big-endian words, writes them from address 0 and verifies an XOR checksum.
module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              LD_start,
  input  logic              LD_byte_valid,
  input  logic [7:0]        LD_byte,
  output logic              LD_byte_ready,
  output logic              LD_imem_we,
  output logic [ADDR_W-1:0] LD_imem_addr,
  output logic [31:0]       LD_imem_data,
  output logic              LD_cpu_hold,
  output logic              LD_done,
  output logic              LD_error
);

  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        xor_q, xor_d;
  logic [31:0]       word_q, word_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;

  // ready_q always mirrors the registered state, so no valid->ready path exists
  assign accept = LD_byte_valid && ready_q;

  // Next-state and next-output decode; every output is re-registered from state_d
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    count_d    = count_q;
    xor_d      = xor_q;
    word_d     = word_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (LD_start) begin
          state_d    = COUNT;
          word_idx_d = '0;
          byte_idx_d = '0;
          xor_d      = '0;
        end
      end
      COUNT: begin
        if (accept) begin
          if (LD_byte == 8'd0 || 32'(LD_byte) > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            count_d = LD_byte;
            xor_d   = LD_byte;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d     = {word_q[23:0], LD_byte};
          xor_d      = xor_q ^ LD_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = WRITE;
            we_d    = 1'b1;
            addr_d  = ADDR_W'({word_idx_q, 2'b00});
            data_d  = {word_q[23:0], LD_byte};
          end
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + IDX_W'(1);
        if (32'(word_idx_q) + 32'd1 == 32'(count_q)) begin
          state_d = CHECK;
        end else begin
          state_d = DATA;
        end
      end
      CHECK: begin
        if (accept) begin
          state_d = (LD_byte == xor_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == COUNT) || (state_d == DATA) || (state_d == CHECK);
    hold_d  = (state_d == COUNT) || (state_d == DATA) || (state_d == WRITE) ||
              (state_d == CHECK) || (state_d == ERR);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERR);
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      count_q    <= '0;
      xor_q      <= '0;
      word_q     <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      count_q    <= count_d;
      xor_q      <= xor_d;
      word_q     <= word_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign LD_byte_ready = ready_q;
  assign LD_imem_we    = we_q;
  assign LD_imem_addr  = addr_q;
  assign LD_imem_data  = data_q;
  assign LD_cpu_hold   = hold_q;
  assign LD_done       = done_q;
  assign LD_error      = error_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that sits directly upstream of the single-cycle CPU's instruction memory. It accepts a framed byte stream from a host through a valid/ready handshake. It assembles big-endian 32-bit instruction words, writes them to consecutive word-aligned IMEM addresses starting at 0, and verifies an XOR checksum. While a load is in progress it holds the CPU in reset; it releases the hold only after a successful load.

## Interface

Parameters:
- ADDR_W, 8, width of the IMEM byte address.
- MAX_WORDS, 64, largest legal word count in a frame. Requirement: 4*MAX_WORDS <= 2^ADDR_W.

Ports:
- SYS_clk  input  1  system clock; all state updates on the rising edge.
- SYS_reset  input  1  asynchronous, active-high reset.
- LD_start  input  1  one-cycle request to begin a new frame.
- LD_byte_valid  input  1  host has a byte on LD_byte.
- LD_byte  input  8  stream byte.
- LD_byte_ready  output  1  loader accepts LD_byte this cycle.
- LD_imem_we  output  1  IMEM write strobe, one cycle per word.
- LD_imem_addr  output  ADDR_W  IMEM byte address (bits [1:0] always 0).
- LD_imem_data  output  32  instruction word to write.
- LD_cpu_hold  output  1  ORed into the CPU's SYS_reset by the top level.
- LD_done  output  1  last frame loaded and checksum matched.
- LD_error  output  1  last frame rejected.

## Operation

- Frame format:
  - byte 0 = word count N;
  - bytes 1..4N = words, most significant byte first;
  - final byte = checksum, the XOR of byte 0 and all 4N data bytes.
- A byte transfers on a rising edge where LD_byte_valid && LD_byte_ready. Neither side otherwise has obligations.
- States: IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR.
  - IDLE/DONE/ERR --LD_start--> COUNT. Clears the word index, byte index and running XOR, and clears LD_done/LD_error.
  - COUNT: ready=1. On accept: N==0 or N>MAX_WORDS -> ERR; else latch N, XOR := byte, go to DATA.
  - DATA: ready=1. Each accepted byte shifts into the word register (word := {word[23:0], byte}) and XORs into the checksum. After the 4th byte go to WRITE.
  - WRITE: ready=0, LD_imem_we=1, LD_imem_addr = word_index*4, LD_imem_data = assembled word. Increment word_index. If word_index+1 == N go to CHECK; else go to DATA.
  - CHECK: ready=1. On accept: if byte == running XOR go to DONE (LD_done=1); else go to ERR (LD_error=1).
  - DONE/ERR: ready=0. Outputs are held until the next LD_start or reset.
- LD_cpu_hold = 1 in COUNT, DATA, WRITE, CHECK and ERR; 0 in IDLE and DONE.
- LD_start is ignored in COUNT, DATA, WRITE and CHECK.
- Words written before a checksum failure are not rolled back. ERR keeps the CPU held, so a corrupt program is never executed.
- Address arithmetic: word_index is wide enough for MAX_WORDS. The address is {word_index, 2'b00} truncated to ADDR_W. The count check guarantees there is no wrap.
- LD_imem_data and LD_imem_addr are don't-care when LD_imem_we=0. Implementations must still drive them from registers, never X.

## Timing

- Reset (asynchronous): state=IDLE. LD_byte_ready=0, LD_imem_we=0, LD_imem_addr=0, LD_imem_data=0, LD_cpu_hold=0, LD_done=0, LD_error=0.
- Reset asserted mid-frame aborts immediately and drops LD_cpu_hold. Partial IMEM contents remain.
- All outputs are registered or are decoded from registered state only. There is no combinational path from LD_byte_valid to LD_byte_ready.
- LD_cpu_hold rises in the cycle after LD_start is sampled.
- Write latency: LD_imem_we is high in the cycle immediately after the edge that accepted the 4th byte of a word.
- Minimum frame time with valid held high is 1 (start) + 1 + 5N + 1 cycles; each word costs 4 accept cycles plus 1 WRITE cycle.
- LD_done/LD_cpu_hold change on the edge that accepts the checksum byte.
- The CPU updates its PC on the falling edge. The top level treats LD_cpu_hold as an additional asynchronous reset. IMEM writes occur on the rising edge, while the CPU is held.

## Test plan

- Normal load:
  - stimulus: start, then stream 02 20 08 00 05 8C 09 00 00 AA with valid held high;
  - required: writes (addr 0x00, 0x20080005) and (addr 0x04, 0x8C090000), each strobe one cycle; LD_done=1; LD_cpu_hold falls on the checksum edge.
- Bad checksum:
  - stimulus: same frame but with checksum 0xAB;
  - required: both writes still occur; LD_error=1; LD_done=0; LD_cpu_hold stays 1; a subsequent correct frame reaches DONE.
- Illegal count:
  - stimulus: count byte 0x00, then a separate frame with count MAX_WORDS+1 (0x41);
  - required: ERR immediately after the count byte, zero writes, ready=0.
- Handshake gaps:
  - stimulus: toggle LD_byte_valid randomly (about 50%) during a 3-word frame;
  - required: identical write sequence; no byte is accepted while ready=0; ready=0 during every WRITE cycle.
- Reset and restart:
  - stimulus: assert SYS_reset asynchronously mid-word in the 2nd word; release it; issue LD_start during COUNT of the new frame;
  - required: all outputs are at their reset values immediately on reset; the second LD_start is ignored; the new frame loads from address 0.
- MAX_WORDS boundary:
  - stimulus: a 64-word frame with incrementing words;
  - required: the last write is at address 0xFC, then LD_done=1.
